// File: rtl/hex_scan_ctrl.sv
// Scan sequencer for an 8-digit active-low seven-segment display with per-slot blanking.
// Optional HEX_SCAN_BLINK_EN adds blink_i and a frame counter that blanks flagged digits on alternate phases.
module hex_scan_ctrl #(
    parameter int CLK_DIV      = 10000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] digits_i,
    input  logic [7:0]  bitmask_i,
`ifdef HEX_SCAN_BLINK_EN
    input  logic [7:0]  blink_i,
`endif
    output logic [6:0]  hex_led,
    output logic [7:0]  hex_sel,
    output logic        frame_o
);

    localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);

    if (CLK_DIV < 2 || BLANK_CYC < 1 || BLANK_CYC >= CLK_DIV || BLINK_FRAMES < 1) begin : g_bad_params
        $error("hex_scan_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       nib_q, nib_d;
    logic             lit_q, lit_d;
    logic [6:0]       led_d;
    logic [7:0]       sel_d;
    logic             frame_d;
    logic             blanked;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

`ifdef HEX_SCAN_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_q, frm_d;
    logic             phase_q, phase_d;

    always_comb begin
        frm_d   = '0;
        phase_d = 1'b0;
        if (en_i) begin
            frm_d   = frm_q;
            phase_d = phase_q;
            if (cnt_q == CNT_LAST && idx_q == 3'd7) begin
                if (frm_q == FRM_LAST) begin
                    frm_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    frm_d = frm_q + FRM_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            frm_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            frm_q   <= frm_d;
            phase_q <= phase_d;
        end
    end

    assign blanked = blink_i[idx_d] & phase_q;
`else
    assign blanked = 1'b0;
`endif

    // Outputs are registered from the next-state values so they line up with cnt/idx in the same cycle.
    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        nib_d   = nib_q;
        lit_d   = lit_q;
        frame_d = 1'b0;
        led_d   = 7'h7F;
        sel_d   = 8'hFF;
        if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                idx_d = idx_q;
            end
            state_d = (cnt_d < CNT_SHOW) ? ST_BLANK : ST_SHOW;
            if (state_d == ST_SHOW && state_q != ST_SHOW) begin
                nib_d = digits_i[{idx_d, 2'b00} +: 4];
                lit_d = bitmask_i[idx_d] & ~blanked;
            end
            frame_d = (idx_d == 3'd7) && (cnt_d == CNT_LAST);
        end
        if (state_d == ST_SHOW) begin
            led_d = seg_decode(nib_d);
            sel_d = lit_d ? ~(8'b1 << idx_d) : 8'hFF;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            nib_q   <= '0;
            lit_q   <= 1'b0;
            hex_led <= 7'h7F;
            hex_sel <= 8'hFF;
            frame_o <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nib_q   <= nib_d;
            lit_q   <= lit_d;
            hex_led <= led_d;
            hex_sel <= sel_d;
            frame_o <= frame_d;
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with CLK_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2.
// Blink sequence is exercised only when HEX_SCAN_BLINK_EN is defined.
module tb_hex_scan_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic        en_i;
    logic [31:0] digits_i;
    logic [7:0]  bitmask_i;
`ifdef HEX_SCAN_BLINK_EN
    logic [7:0]  blink_i;
`endif
    logic [6:0]  hex_led;
    logic [7:0]  hex_sel;
    logic        frame_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sel_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [6:0] led_tab [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    hex_scan_ctrl #(
        .CLK_DIV      (8),
        .BLANK_CYC    (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .digits_i  (digits_i),
        .bitmask_i (bitmask_i),
`ifdef HEX_SCAN_BLINK_EN
        .blink_i   (blink_i),
`endif
        .hex_led   (hex_led),
        .hex_sel   (hex_sel),
        .frame_o   (frame_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] esel, input logic [6:0] eled,
                           input logic efrm);
        chk({tag, "_sel"}, 32'(hex_sel), 32'(esel));
        chk({tag, "_led"}, 32'(hex_led), 32'(eled));
        chk({tag, "_frm"}, 32'(frame_o), 32'(efrm));
    endtask

    // Entered at cnt=0 of slot k, leaves at cnt=0 of the following slot.
    task automatic run_slot(input int k, input logic [7:0] esel, input logic [6:0] eled);
        for (int c = 0; c < 8; c++) begin
            if (c < 2) chk_out($sformatf("s%0d_c%0d", k, c), 8'hFF, 7'h7F, 1'b0);
            else       chk_out($sformatf("s%0d_c%0d", k, c), esel, eled, (k == 7 && c == 7));
            step();
        end
    endtask

    initial begin
        rst_i     = 1'b1;
        en_i      = 1'b1;
        digits_i  = 32'h7654_3210;
        bitmask_i = 8'hFF;
`ifdef HEX_SCAN_BLINK_EN
        blink_i   = 8'h00;
`endif
        #3 rst_i = 1'b0;
        #1 chk_out("rst_async", 8'hFF, 7'h7F, 1'b0);
        step();
        step();
        chk_out("rst_held", 8'hFF, 7'h7F, 1'b0);
        rst_i = 1'b1;

        // Full frame, every digit lit; last slot pulses frame_o.
        for (int k = 0; k < 8; k++) run_slot(k, sel_tab[k], led_tab[k]);

        // Mask changed during BLANK of slot 0 applies to this frame.
        bitmask_i = 8'hAA;
        for (int k = 0; k < 8; k++) run_slot(k, k[0] ? sel_tab[k] : 8'hFF, led_tab[k]);

        bitmask_i = 8'hFF;
        for (int k = 0; k < 3; k++) run_slot(k, sel_tab[k], led_tab[k]);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) digits_i = 32'hFFFF_FFFF;
            if (c < 2) chk_out($sformatf("late_c%0d", c), 8'hFF, 7'h7F, 1'b0);
            else       chk_out($sformatf("late_c%0d", c), 8'hF7, 7'h30, 1'b0);
            step();
        end
        for (int c = 0; c < 6; c++) begin
            if (c < 2) chk_out($sformatf("s4f_c%0d", c), 8'hFF, 7'h7F, 1'b0);
            else       chk_out($sformatf("s4f_c%0d", c), 8'hEF, 7'h0E, 1'b0);
            if (c < 5) step();
        end
        en_i = 1'b0;
        step();
        chk_out("en_off", 8'hFF, 7'h7F, 1'b0);
        step();
        chk_out("idle", 8'hFF, 7'h7F, 1'b0);
        en_i = 1'b1;
        step();
        chk_out("restart_c1", 8'hFF, 7'h7F, 1'b0);
        step();
        chk_out("restart_c2", 8'hFE, 7'h0E, 1'b0);
        step();
        chk_out("restart_c3", 8'hFE, 7'h0E, 1'b0);

        // Asynchronous reset between edges while showing.
        #2 rst_i = 1'b0;
        #1 chk_out("rst_mid", 8'hFF, 7'h7F, 1'b0);
        step();
        rst_i    = 1'b1;
        digits_i = 32'h7654_3210;
        run_slot(0, sel_tab[0], led_tab[0]);
        run_slot(1, sel_tab[1], led_tab[1]);

`ifdef HEX_SCAN_BLINK_EN
        rst_i   = 1'b0;
        blink_i = 8'h01;
        step();
        rst_i = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 8; k++) begin
                run_slot(k, (k == 0 && (f == 2 || f == 3)) ? 8'hFF : sel_tab[k], led_tab[k]);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
